// File: rtl/chain_print_ctl.sv
`default_nettype none
// ============================================================================
// Module  : chain_print_ctl
// Brief   : Chain-printer line buffer and hammer controller (load, scan, fire).
// Revision: 1.0 - initial release
// ============================================================================
module chain_print_ctl #(
    parameter int unsigned LINE_LEN  = 132,
    parameter int unsigned CHAIN_LEN = 240
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load_valid,
    input  logic [7:0] i_load_data,
    input  logic       i_load_last,
    output logic       o_load_ready,
    output logic [7:0] o_xlat_ebcdic,
    input  logic [5:0] i_xlat_bcd,
    input  logic       i_xlat_space,
    input  logic       i_xlat_unassigned,
    input  logic       i_print,
    input  logic       i_chain_strobe,
    input  logic [5:0] i_chain_bcd,
    output logic       o_hammer_fire,
    output logic [7:0] o_hammer_pos,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_data_check,
    output logic       o_print_check,
    output logic       o_overrun
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SCAN  = 3'd4
    } state_t;

    state_t           state_q;
    logic [7:0]       wp_q;
    logic [7:0]       idx_q;
    logic [5:0]       code_q;
    logic [CNT_W-1:0] strobe_cnt_q;
    logic [7:0]       pend_cnt_q;
    logic [7:0]       pend_cnt_d;
    logic             pend_q [LINE_LEN];
    logic [5:0]       bcd_q  [LINE_LEN];
    logic             done_q;
    logic             data_check_q;
    logic             print_check_q;
    logic             overrun_q;

    logic             w_accept;
    logic             w_first;
    logic [7:0]       w_widx;
    logic             w_wr_pend;
    logic             w_wr_bad;
    logic             w_load_end;
    logic             w_match;
    logic             w_scan_last;

    assign o_load_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign o_xlat_ebcdic = i_load_data;

    assign w_accept    = o_load_ready & i_load_valid;
    assign w_first     = w_accept & (state_q == ST_IDLE);
    assign w_widx      = (state_q == ST_IDLE) ? 8'd0 : wp_q;
    // A blank code wins over an unassigned flag: it is simply not printed.
    assign w_wr_pend   = ~i_xlat_space & ~i_xlat_unassigned;
    assign w_wr_bad    = ~i_xlat_space &  i_xlat_unassigned;
    assign w_load_end  = w_accept & (i_load_last | (w_widx == 8'(LINE_LEN - 1)));
    assign w_scan_last = (state_q == ST_SCAN) && (idx_q == 8'(LINE_LEN - 1));

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < LINE_LEN; i++) begin
            if ((idx_q == 8'(i)) && pend_q[i] && (bcd_q[i] == code_q)) begin
                w_match = 1'b1;
            end
        end
        if (state_q != ST_SCAN) begin
            w_match = 1'b0;
        end
    end

    assign o_hammer_fire = w_match;
    assign o_hammer_pos  = idx_q;

    // Pending count lets the end-of-scan decision avoid a wide OR over the buffer.
    always_comb begin
        pend_cnt_d = pend_cnt_q;
        if (w_accept) begin
            pend_cnt_d = (w_first ? 8'd0 : pend_cnt_q) + {7'd0, w_wr_pend};
        end else if (w_match) begin
            pend_cnt_d = pend_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < LINE_LEN; i++) begin
                pend_q[i] <= 1'b0;
                bcd_q[i]  <= 6'd0;
            end
        end else begin
            for (int i = 0; i < LINE_LEN; i++) begin
                if (w_accept) begin
                    if (w_widx == 8'(i)) begin
                        pend_q[i] <= w_wr_pend;
                        bcd_q[i]  <= i_xlat_bcd;
                    end else if (w_load_end && (8'(i) > w_widx)) begin
                        pend_q[i] <= 1'b0;
                    end
                end else if (w_match && (idx_q == 8'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= ST_IDLE;
            wp_q          <= 8'd0;
            idx_q         <= 8'd0;
            code_q        <= 6'd0;
            strobe_cnt_q  <= '0;
            pend_cnt_q    <= 8'd0;
            done_q        <= 1'b0;
            data_check_q  <= 1'b0;
            print_check_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            pend_cnt_q <= pend_cnt_d;

            if (w_first) begin
                data_check_q  <= w_wr_bad;
                print_check_q <= 1'b0;
                overrun_q     <= 1'b0;
            end else if (w_accept && w_wr_bad) begin
                data_check_q  <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept) begin
                        wp_q    <= w_widx + 8'd1;
                        state_q <= w_load_end ? ST_READY : ST_LOAD;
                    end
                end
                ST_READY: begin
                    if (i_print) begin
                        strobe_cnt_q <= '0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_chain_strobe) begin
                        code_q       <= i_chain_bcd;
                        strobe_cnt_q <= strobe_cnt_q + CNT_W'(1);
                        idx_q        <= 8'd0;
                        state_q      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (i_chain_strobe) begin
                        overrun_q <= 1'b1;
                    end
                    if (w_scan_last) begin
                        idx_q <= 8'd0;
                        wp_q  <= 8'd0;
                        if (pend_cnt_d == 8'd0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (strobe_cnt_q == CNT_W'(CHAIN_LEN)) begin
                            print_check_q <= 1'b1;
                            state_q       <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;
    assign o_data_check  = data_check_q;
    assign o_print_check = print_check_q;
    assign o_overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_print_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_chain_print_ctl
// Brief   : Directed and randomized bench for chain_print_ctl against a line model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_chain_print_ctl;

    localparam int LINE  = 132;
    localparam int CHAIN = 240;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       i_reset;
    logic       i_load_valid;
    logic [7:0] i_load_data;
    logic       i_load_last;
    logic       i_print;
    logic       i_chain_strobe;
    logic [5:0] i_chain_bcd;

    wire        ready, fire, busy, done, dchk, pchk, ovr;
    wire [7:0]  xebc, pos;
    wire        s_ready, s_fire, s_busy, s_done, s_dchk, s_pchk, s_ovr;
    wire [7:0]  s_xebc, s_pos;
    wire [7:0]  xl_word;

    // Translator model: space 40, zones C/D/E/F with digits 1-9 assigned, rest unassigned.
    function automatic logic [7:0] xl(input logic [7:0] b);
        logic       sp, un;
        logic [5:0] bcd;
        sp  = (b == 8'h40);
        un  = !sp && !((b[7:6] == 2'b11) && (b[3:0] >= 4'd1) && (b[3:0] <= 4'd9));
        bcd = sp ? 6'd0 : (un ? b[5:0] : {~b[5:4], b[3:0]});
        return {un, sp, bcd};
    endfunction

    assign xl_word = xl(xebc);

    chain_print_ctl #(.LINE_LEN(LINE), .CHAIN_LEN(CHAIN)) u_dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_last(i_load_last),
        .o_load_ready(ready), .o_xlat_ebcdic(xebc),
        .i_xlat_bcd(xl_word[5:0]), .i_xlat_space(xl_word[6]), .i_xlat_unassigned(xl_word[7]),
        .i_print(i_print), .i_chain_strobe(i_chain_strobe), .i_chain_bcd(i_chain_bcd),
        .o_hammer_fire(fire), .o_hammer_pos(pos), .o_busy(busy), .o_done(done),
        .o_data_check(dchk), .o_print_check(pchk), .o_overrun(ovr)
    );

    chain_print_ctl #(.LINE_LEN(LINE), .CHAIN_LEN(4)) u_small (
        .i_clk(clk), .i_reset(i_reset),
        .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_last(i_load_last),
        .o_load_ready(s_ready), .o_xlat_ebcdic(s_xebc),
        .i_xlat_bcd(xl_word[5:0]), .i_xlat_space(xl_word[6]), .i_xlat_unassigned(xl_word[7]),
        .i_print(i_print), .i_chain_strobe(i_chain_strobe), .i_chain_bcd(i_chain_bcd),
        .o_hammer_fire(s_fire), .o_hammer_pos(s_pos), .o_busy(s_busy), .o_done(s_done),
        .o_data_check(s_dchk), .o_print_check(s_pchk), .o_overrun(s_ovr)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Line model: which positions still await a hammer and with what code.
    bit         m_pend [LINE];
    logic [5:0] m_code [LINE];
    int         m_wp, m_phase, m_strobes;   // phase 0 free, 1 loaded, 2 printing
    bit         m_open, m_dchk, m_ovr, m_pchk;

    int fires_q [$];
    int fires4_cnt;
    int last4_pos;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < LINE; p++) m_pend[p] = 1'b0;
        m_wp = 0; m_phase = 0; m_strobes = 0;
        m_open = 0; m_dchk = 0; m_ovr = 0; m_pchk = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
    endtask

    task automatic model_accept(input logic [7:0] b, input bit last);
        logic [7:0] t;
        if (!m_open) begin
            for (int p = 0; p < LINE; p++) m_pend[p] = 1'b0;
            m_wp = 0; m_open = 1; m_dchk = 0; m_ovr = 0; m_pchk = 0;
        end
        t = xl(b);
        if (!t[6]) begin
            if (t[7]) m_dchk = 1;
            else begin
                m_pend[m_wp] = 1'b1;
                m_code[m_wp] = t[5:0];
            end
        end
        if (last || m_wp == LINE - 1) begin
            m_open = 0; m_phase = 1;
        end else begin
            m_wp++;
        end
    endtask

    task automatic load_bytes(input bq_t bs, input bit with_last);
        bit acc;
        for (int i = 0; i < bs.size(); i++) begin
            i_load_valid = 1'b1;
            i_load_data  = bs[i];
            i_load_last  = with_last && (i == bs.size() - 1);
            acc = (m_phase == 0);
            #1;
            check("load_ready", {31'd0, ready}, {31'd0, acc});
            @(negedge clk);
            if (acc) model_accept(bs[i], i_load_last);
        end
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
        check("load_dchk", {31'd0, dchk}, {31'd0, m_dchk});
        check("load_busy", {31'd0, busy}, {31'd0, (m_open || m_phase != 0)});
    endtask

    task automatic do_print();
        i_print = 1'b1;
        @(negedge clk);
        i_print = 1'b0;
        if (m_phase == 1) begin
            m_phase = 2; m_strobes = 0;
        end
        check("print_busy", {31'd0, busy}, {31'd0, (m_open || m_phase != 0)});
    endtask

    // One strobe followed by a full scan; ovr_at >= 0 injects a stray strobe.
    task automatic scan_once(input logic [5:0] code, input int ovr_at);
        fires_q.delete();
        fires4_cnt = 0;
        i_chain_bcd    = code;
        i_chain_strobe = 1'b1;
        for (int k = 0; k < LINE; k++) begin
            @(negedge clk);
            i_chain_strobe = (k == ovr_at);
            i_chain_bcd    = (k == ovr_at) ? ~code : code;
            if (fire) fires_q.push_back(int'(pos));
            if (s_fire) begin
                fires4_cnt++;
                last4_pos = int'(s_pos);
            end
        end
        @(negedge clk);
        i_chain_strobe = 1'b0;
    endtask

    task automatic scan_check(input logic [5:0] code, input int ovr_at);
        int exp_q [$];
        int rem, n;
        bit e_done;
        for (int p = 0; p < LINE; p++) begin
            if (m_pend[p] && m_code[p] == code) begin
                exp_q.push_back(p);
                m_pend[p] = 1'b0;
            end
        end
        scan_once(code, ovr_at);
        check("fire_count", fires_q.size(), exp_q.size());
        n = (fires_q.size() < exp_q.size()) ? fires_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("fire_pos", fires_q[i], exp_q[i]);
        m_strobes++;
        if (ovr_at >= 0) m_ovr = 1;
        rem = 0;
        for (int p = 0; p < LINE; p++) rem += int'(m_pend[p]);
        e_done = (rem == 0);
        if (rem == 0) m_phase = 0;
        else if (m_strobes == CHAIN) begin
            m_pchk = 1; m_phase = 0;
        end
        check("scan_done", {31'd0, done}, {31'd0, e_done});
        check("scan_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
        check("scan_ovr",  {31'd0, ovr},  {31'd0, m_ovr});
        check("scan_pchk", {31'd0, pchk}, {31'd0, m_pchk});
        check("scan_dchk", {31'd0, dchk}, {31'd0, m_dchk});
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 8'h40;
        if (r == 2) return ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h4B;
        return {2'b11, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 3))};
    endfunction

    initial begin
        bq_t bs;
        int  nf, len, guard, pick;
        int  pend_list [$];

        i_reset = 1'b0; i_load_valid = 1'b0; i_load_data = 8'h00; i_load_last = 1'b0;
        i_print = 1'b0; i_chain_strobe = 1'b0; i_chain_bcd = 6'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_fire",  {31'd0, fire},  32'd0);
        check("rst_flags", {29'd0, dchk, pchk, ovr}, 32'd0);
        i_reset = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);

        // Print ignored outside READY.
        do_print();

        // Three characters, three strobes.
        bs = '{8'hC1, 8'hC2, 8'hC3};
        load_bytes(bs, 1'b1);
        do_print();
        scan_check(6'b110001, -1);
        scan_check(6'b110010, -1);
        scan_check(6'b110011, -1);

        // Full line without last: 133rd offer refused.
        bs.delete();
        for (int i = 0; i < LINE + 1; i++) bs.push_back(8'hC1);
        load_bytes(bs, 1'b0);
        do_print();
        scan_check(6'b110001, -1);

        // Leading space never fires.
        bs = '{8'h40, 8'hC1};
        load_bytes(bs, 1'b1);
        do_print();
        scan_check(6'b110001, -1);

        // Unassigned byte flags data check and never fires.
        bs = '{8'hFF, 8'hC1};
        load_bytes(bs, 1'b1);
        do_print();
        scan_check(6'b111111, -1);
        scan_check(6'b110001, -1);

        // Blank line still needs one scan; first byte clears data check.
        bs = '{8'h40};
        load_bytes(bs, 1'b1);
        do_print();
        scan_check(6'b010101, -1);

        // Overrun during scan, then reset mid-scan.
        bs.delete();
        bs.push_back(8'hC1);
        for (int i = 0; i < 98; i++) bs.push_back(8'h40);
        bs.push_back(8'hC2);
        load_bytes(bs, 1'b1);
        do_print();
        scan_check(6'b110001, 1);
        i_chain_bcd = 6'b110010;
        i_chain_strobe = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            i_chain_strobe = 1'b0;
        end
        i_reset = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_fire", {31'd0, fire}, 32'd0);
        check("midrst_ovr",  {31'd0, ovr},  32'd0);
        nf = 0;
        for (int k = 0; k < LINE + 10; k++) begin
            @(negedge clk);
            if (k == 3) i_reset = 1'b1;
            if (fire) nf++;
        end
        check("midrst_nofire", nf, 0);
        check("midrst_ready", {31'd0, ready}, 32'd1);

        // Chain of four: print check after fourth unproductive scan.
        do_reset();
        bs = '{8'hC1};
        load_bytes(bs, 1'b1);
        check("small_xebc", {24'd0, s_xebc}, {24'd0, i_load_data});
        do_print();
        for (int s = 0; s < 4; s++) begin
            scan_check(6'b000001, -1);
            check("small_nofire", fires4_cnt, 0);
        end
        check("small_pchk",  {31'd0, s_pchk},  32'd1);
        check("small_busy",  {31'd0, s_busy},  32'd0);
        check("small_ready", {31'd0, s_ready}, 32'd1);
        check("small_other", {29'd0, s_done, s_dchk, s_ovr}, 32'd0);
        do_reset();

        // Randomized lines against the model.
        for (int r = 0; r < 4; r++) begin
            bs.delete();
            len = $urandom_range(1, LINE);
            for (int i = 0; i < len; i++) bs.push_back(rand_byte());
            load_bytes(bs, len < LINE);
            do_print();
            guard = 0;
            while (m_phase == 2 && guard < 40) begin
                pend_list.delete();
                for (int p = 0; p < LINE; p++) if (m_pend[p]) pend_list.push_back(p);
                if (pend_list.size() > 0 && $urandom_range(0, 3) != 0) begin
                    pick = pend_list[$urandom_range(0, pend_list.size() - 1)];
                    scan_check(m_code[pick], ($urandom_range(0, 4) == 0) ? $urandom_range(0, LINE - 1) : -1);
                end else begin
                    scan_check(6'($urandom_range(0, 63)), -1);
                end
                guard++;
            end
            if (m_phase != 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
